// File: rtl/piccolo_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : piccolo_io_ctrl
// Description : Word-serial front end for a Piccolo block-cipher core.
//               Collects a 16-bit MSB-first stream of key words (5 for an
//               80-bit key, 8 for a 128-bit key) and 4 plaintext words, then
//               pulses core_load. It waits CORE_LAT cycles, captures core_ct,
//               and offers the result on a valid/ready output port.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   PICCOLO_KEY_REUSE_EN - when defined, a block whose first word arrives with
//                          in_keep=1 skips the key phase and reuses the stored
//                          key/version (only once a key has been fully loaded
//                          since reset).
// Parameters:
//   CORE_LAT     - cycles spent in WAIT before core_ct is captured (1..31)
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-low reset
//   in_valid     - input word present
//   in_ready     - word accepted this cycle (IDLE/KEY/PT)
//   in_data      - 16-bit key or plaintext word
//   in_version   - key size (0 = 80-bit, 1 = 128-bit), sampled on first word
//   in_keep      - key-reuse request, sampled on first word
//   core_load    - one-cycle load strobe to the core
//   core_version - version presented to the core
//   core_pt      - assembled plaintext (first word in the top 16 bits)
//   core_key     - assembled key (first word in the top 16 bits)
//   core_ct      - ciphertext from the core
//   out_valid    - ciphertext available
//   out_ready    - consumer accepts out_data
//   out_data     - captured ciphertext
//   busy         - high in every state except IDLE
// ============================================================================
module piccolo_io_ctrl #(
  parameter int CORE_LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_data,
  input  logic         in_version,
  input  logic         in_keep,
  output logic         core_load,
  output logic         core_version,
  output logic [63:0]  core_pt,
  output logic [127:0] core_key,
  input  logic [63:0]  core_ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_PT   = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  // WAIT counts down from CORE_LAT-1 to 0, giving exactly CORE_LAT cycles.
  localparam logic [4:0] LAT_INIT = 5'(CORE_LAT - 1);

  logic [2:0]   state_q, state_d;
  logic [2:0]   cnt_q,   cnt_d;
  logic [4:0]   lat_q,   lat_d;
  logic         ver_q,   ver_d;
  logic [63:0]  pt_q,    pt_d;
  logic [127:0] key_q,   key_d;
  logic [63:0]  out_q,   out_d;
  logic         w_accept;

`ifdef PICCOLO_KEY_REUSE_EN
  // Set once a complete key has been captured; only then may in_keep skip KEY.
  logic         keyok_q, keyok_d;
`else
  logic         w_unused_keep;
  assign w_unused_keep = in_keep;
`endif

  assign in_ready     = (state_q == S_IDLE) || (state_q == S_KEY) || (state_q == S_PT);
  assign w_accept     = in_valid && in_ready;
  assign core_load    = (state_q == S_LOAD);
  assign out_valid    = (state_q == S_OUT);
  assign busy         = (state_q != S_IDLE);
  assign core_version = ver_q;
  assign core_pt      = pt_q;
  assign core_key     = key_q;
  assign out_data     = out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    ver_d   = ver_q;
    pt_d    = pt_q;
    key_d   = key_q;
    out_d   = out_q;
`ifdef PICCOLO_KEY_REUSE_EN
    keyok_d = keyok_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          cnt_d = 3'd1;
`ifdef PICCOLO_KEY_REUSE_EN
          if (in_keep && keyok_q) begin
            // Reuse path: first word is plaintext word 0; key and version kept.
            pt_d    = {in_data, 48'h0};
            state_d = S_PT;
          end else begin
            ver_d   = in_version;
            key_d   = {in_data, 112'h0};
            state_d = S_KEY;
          end
`else
          // Writing word 0 also clears the rest, so an 80-bit key ends in zeros.
          ver_d   = in_version;
          key_d   = {in_data, 112'h0};
          state_d = S_KEY;
`endif
        end
      end

      S_KEY: begin
        if (w_accept) begin
          for (int i = 1; i < 8; i++) begin
            if (cnt_q == 3'(i)) key_d[127-16*i -: 16] = in_data;
          end
          if (cnt_q == (ver_q ? 3'd7 : 3'd4)) begin
            cnt_d   = 3'd0;
            state_d = S_PT;
`ifdef PICCOLO_KEY_REUSE_EN
            keyok_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_PT: begin
        if (w_accept) begin
          for (int i = 0; i < 4; i++) begin
            if (cnt_q[1:0] == 2'(i)) pt_d[63-16*i -: 16] = in_data;
          end
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_LOAD: begin
        lat_d   = LAT_INIT;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (lat_q == 5'd0) begin
          out_d   = core_ct;
          state_d = S_OUT;
        end else begin
          lat_d = lat_q - 5'd1;
        end
      end

      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      lat_q   <= 5'd0;
      ver_q   <= 1'b0;
      pt_q    <= 64'h0;
      key_q   <= 128'h0;
      out_q   <= 64'h0;
`ifdef PICCOLO_KEY_REUSE_EN
      keyok_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      ver_q   <= ver_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      out_q   <= out_d;
`ifdef PICCOLO_KEY_REUSE_EN
      keyok_q <= keyok_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piccolo_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_piccolo_io_ctrl
// Description : Scoreboard bench for piccolo_io_ctrl. A word-list reference
//               model predicts each core load and ciphertext; a negedge
//               monitor compares DUT activity against the expected queues.
//               Honours PICCOLO_KEY_REUSE_EN the same way as the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_piccolo_io_ctrl;
  localparam int CORE_LAT = 3;
`ifdef PICCOLO_KEY_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_version, in_keep;
  logic [15:0]  in_data;
  logic         core_load, core_version;
  logic [63:0]  core_pt, core_ct, out_data;
  logic [127:0] core_key;
  logic         out_valid, out_ready, busy;
  int           or_mode;

  typedef struct packed {
    logic [127:0] key;
    logic [63:0]  pt;
    logic         ver;
  } load_t;

  load_t       loadq[$];
  logic [63:0] outq[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  piccolo_io_ctrl #(.CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_version(in_version), .in_keep(in_keep),
    .core_load(core_load), .core_version(core_version), .core_pt(core_pt),
    .core_key(core_key), .core_ct(core_ct), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Stand-in cipher: any mixing function works as long as both sides agree.
  function automatic logic [63:0] fcore(input logic [63:0] pt, input logic [127:0] key, input logic v);
    return pt ^ key[127:64] ^ {key[31:0], key[63:32]} ^ {64{v}};
  endfunction

  // Core model: result is only valid on the CORE_LAT-th cycle after the load.
  logic        core_act;
  int          core_n;
  logic [63:0] core_res;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_act <= 1'b0;
      core_n   <= 0;
      core_res <= 64'h0;
    end else if (core_load) begin
      core_act <= 1'b1;
      core_n   <= 1;
      core_res <= fcore(core_pt, core_key, core_version);
    end else if (core_act) begin
      core_n   <= core_n + 1;
    end
  end
  assign core_ct = (core_act && core_n == CORE_LAT) ? core_res
                                                    : (64'hA5A5_5A5A_0F0F_F0F0 ^ 64'(core_n));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: words of the current block -------------
  logic [15:0]  cw[$];
  logic         cver, creuse, sver;
  logic         have_key = 1'b0;
  logic [127:0] skey;

  task automatic model_accept(input logic [15:0] d, input logic v, input logic k);
    int    nk;
    load_t e;
    if (cw.size() == 0) begin
      creuse = REUSE && k && have_key;
      cver   = creuse ? sver : v;
    end
    cw.push_back(d);
    nk = creuse ? 0 : (cver ? 8 : 5);
    if (cw.size() == nk + 4) begin
      e.key = creuse ? skey : 128'h0;
      for (int i = 0; i < nk; i++) e.key[127-16*i -: 16] = cw[i];
      for (int i = 0; i < 4; i++)  e.pt[63-16*i -: 16]   = cw[nk+i];
      e.ver = cver;
      loadq.push_back(e);
      outq.push_back(fcore(e.pt, e.key, e.ver));
      skey     = e.key;
      sver     = cver;
      have_key = 1'b1;
      cw.delete();
    end
  endtask

  task automatic model_reset();
    cw.delete();
    loadq.delete();
    outq.delete();
    have_key = 1'b0;
  endtask

  // ---------------- monitor ----------------------------------------------------
  int          cyc = 0;
  int          load_cyc = -1000;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [63:0] pd = 64'h0;
  load_t       me;
  logic [63:0] mo;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      chk("in_ready", in_ready, outq.size() == 0);
      chk("busy", busy, (cw.size() != 0) || (outq.size() != 0));
      if (core_load) begin
        chk("load_single_cycle", pl, 1'b0);
        if (loadq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: core_load high with no block pending");
        end else begin
          me = loadq.pop_front();
          chk("core_key", core_key, me.key);
          chk("core_pt", core_pt, me.pt);
          chk("core_version", core_version, me.ver);
        end
        load_cyc <= cyc;
      end
      if (out_valid && !pv) chk("latency", 128'(cyc - load_cyc), 128'(CORE_LAT + 1));
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, pd);
      end
      if (out_valid && out_ready) begin
        if (outq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: out_valid with no result pending, got %h", out_data);
        end else begin
          mo = outq.pop_front();
          chk("out_data", out_data, mo);
        end
      end
    end
    pv <= reset && out_valid;
    pr <= out_ready;
    pl <= reset && core_load;
    pd <= out_data;
  end

  // ---------------- output-side driver -----------------------------------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- input-side driver (called at posedge+1) -------------------
  task automatic send_word(input logic [15:0] d, input logic v, input logic k, input int gap);
    bit acc;
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_version = v; in_keep = k;
    acc = 1'b0; n = 0;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 200) begin
        $display("FAIL accept_timeout: word %h never accepted", d);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "input stalled");
      end
    end
    model_accept(d, v, k);
    in_valid = 1'b0; in_data = 16'($urandom);
    in_version = 1'($urandom); in_keep = 1'($urandom);
  endtask

  task automatic send_rand_block(input int gapmax);
    send_word(16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, gapmax));
    while (cw.size() != 0)
      send_word(16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, gapmax));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while ((busy || outq.size() != 0) && n < 2000);
    if (n >= 2000) begin
      $display("FAIL idle_timeout: busy=%0d pending=%0d", busy, outq.size());
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "design stuck");
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_core_load"}, core_load, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_core_version"}, core_version, 1'b0);
    chk({tag, "_core_key"}, core_key, 128'h0);
    chk({tag, "_core_pt"}, core_pt, 64'h0);
    chk({tag, "_out_data"}, out_data, 64'h0);
  endtask

  logic [15:0]  w35[12];
  logic [127:0] kprev;
  logic [63:0]  hold_d;
  int           n;

  initial begin
    w35 = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'haabb,
            16'hccdd, 16'heeff, 16'h0123, 16'h4567, 16'h89ab, 16'hcdef};
    in_valid = 1'b0; in_data = 16'h0; in_version = 1'b0; in_keep = 1'b0;
    or_mode = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;

    // 128-bit key block, continuous input
    for (int i = 0; i < 12; i++) send_word(w35[i], (i == 0), 1'b0, 0);
    @(negedge clk);
    chk("v1_load", core_load, 1'b1);
    chk("v1_key", core_key, 128'h00112233445566778899aabbccddeeff);
    chk("v1_pt", core_pt, 64'h0123456789abcdef);
    wait_idle();

    // 80-bit key block: LOAD only after the 9th word
    for (int i = 0; i < 9; i++) begin
      send_word((i < 5) ? w35[i] : w35[i+3], 1'b0, 1'b0, 0);
      if (i == 7) begin
        @(negedge clk);
        chk("v0_no_early_load", core_load, 1'b0);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("v0_load", core_load, 1'b1);
    chk("v0_key", core_key, {80'h00112233445566778899, 48'h0});
    chk("v0_version", core_version, 1'b0);
    wait_idle();

    // output back-pressure held for 10 cycles
    or_mode = 1;
    send_word(16'hbeef, 1'b0, 1'b0, 0);
    while (cw.size() != 0) send_word(16'($urandom), 1'($urandom), 1'($urandom), 0);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_out_valid", out_valid, 1'b1);
    hold_d = out_data;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, hold_d);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    or_mode = 2;
    wait_idle();
    chk("bp_idle_in_ready", in_ready, 1'b1);
    or_mode = 0;

    // key reuse request after a full block
    send_rand_block(0);
    wait_idle();
    kprev = skey;
    send_word(16'h1357, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 1'($urandom), 1'($urandom), 0);
    @(negedge clk);
    chk("reuse_load", core_load, REUSE);
    if (REUSE) chk("reuse_key", core_key, kprev);
    @(posedge clk); #1;
    while (cw.size() != 0) send_word(16'($urandom), 1'($urandom), 1'($urandom), 0);
    wait_idle();

    // every-other-cycle input must give the same result as continuous input
    for (int i = 0; i < 12; i++) send_word(w35[i], (i == 0), 1'b0, 1);
    @(negedge clk);
    chk("gap_key", core_key, 128'h00112233445566778899aabbccddeeff);
    chk("gap_pt", core_pt, 64'h0123456789abcdef);
    wait_idle();

    // reset in the middle of the key phase
    for (int i = 0; i < 6; i++) send_word(w35[i], 1'b1, 1'b0, 0);
    reset = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("mid");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) send_word(w35[i], (i == 0), (i == 0), 0);
    @(negedge clk);
    chk("post_rst_load", core_load, 1'b1);
    chk("post_rst_key", core_key, 128'h00112233445566778899aabbccddeeff);
    wait_idle();

    // randomized blocks with random gaps and back-pressure
    for (int b = 0; b < 40; b++) send_rand_block(2);
    wait_idle();
    chk("final_queues_empty", 128'(loadq.size() + outq.size()), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/piccolo_io_ctrl.md
PICCOLO_IO_CTRL -- requirements
Module: piccolo_io_ctrl

Interface
REQ-001 Parameter CORE_LAT, default 3: clock cycles from core_load deassertion until core_ct is valid; legal range 1..31.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  input word present.
REQ-005 in_ready  output  1  controller accepts in_data this cycle.
REQ-006 in_data  input  16  key or plaintext word, MSB-first order.
REQ-007 in_version  input  1  sampled with the first word of a block: 0 = 80-bit key, 1 = 128-bit key.
REQ-008 in_keep  input  1  sampled with the first word: reuse the stored key; effective only under the REQ-033 macro.
REQ-009 core_load  output  1  active-high load strobe to the Piccolo core.
REQ-010 core_version  output  1  version presented to the core.
REQ-011 core_pt  output  64  assembled plaintext, bit 0 = MSB.
REQ-012 core_key  output  128  assembled key, bit 0 = MSB.
REQ-013 core_ct  input  64  ciphertext from the core.
REQ-014 out_valid  output  1  ciphertext available.
REQ-015 out_ready  input  1  consumer accepts out_data.
REQ-016 out_data  output  64  captured ciphertext.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, KEY, PT, LOAD, WAIT and OUT; a word transfers only on a cycle with in_valid and in_ready both high.
REQ-019 in_ready SHALL be high in IDLE, KEY and PT, and low in LOAD, WAIT and OUT.
REQ-020 In IDLE, an accepted word SHALL latch in_version and SHALL be stored as key word 0, then move to KEY (or to PT per REQ-033).
REQ-021 Key word count SHALL be 5 for version 0 and 8 for version 1; word i SHALL occupy core_key bits [16i:16i+15].
REQ-022 For version 0, core_key bits [80:127] SHALL be zero.
REQ-023 When the final key word is accepted, the state SHALL move to PT, and exactly 4 plaintext words SHALL fill core_pt in order [0:15] through [48:63].
REQ-024 The cycle after the 4th plaintext word is accepted, the state SHALL be LOAD, with core_load high for exactly one cycle and core_pt, core_key and core_version stable.
REQ-025 WAIT SHALL last exactly CORE_LAT cycles, counted by a 5-bit down-counter; on its final cycle core_ct SHALL be captured into out_data.
REQ-026 In OUT, out_valid SHALL be high, and out_data SHALL be held until out_valid and out_ready are both high; the state SHALL then return to IDLE with out_valid low on the next cycle.
REQ-027 core_pt, core_key and core_version SHALL stay unchanged from LOAD until the next block starts loading.
REQ-028 in_valid without in_ready SHALL have no effect, and in_data SHALL be ignored outside accepted cycles.
REQ-029 A block already started SHALL complete regardless of later in_version or in_keep values.

Reset
REQ-030 Asserting reset low at any time, including mid-block, SHALL immediately force IDLE, clear the word and latency counters, set core_load, out_valid and core_version to 0, and zero core_pt, core_key and out_data.
REQ-031 Immediately after reset is released, in_ready SHALL be high, busy SHALL be low, and the next accepted word SHALL be treated as key word 0.

Configuration
REQ-032 Macro PICCOLO_KEY_REUSE_EN SHALL select whether key reuse is compiled in.
REQ-033 With the macro defined: if in_keep is high on the first accepted word of a block and a key has been fully loaded since reset, that word SHALL be plaintext word 0, KEY SHALL be skipped, and the stored key and version SHALL be reused; if no key has been loaded since reset, in_keep SHALL be ignored.
REQ-034 With the macro undefined: in_keep SHALL be ignored and every block SHALL load a full key.

Verification
REQ-035 Version 1; key words 0011,2233,4455,6677,8899,aabb,ccdd,eeff; plaintext 0123,4567,89ab,cdef -> core_key = 00112233445566778899aabbccddeeff, core_pt = 0123456789abcdef, core_load high one cycle, out_valid high exactly CORE_LAT+1 cycles after core_load.
REQ-036 Version 0; 5 key words 0011..8899 -> core_key = 00112233445566778899 followed by 48 zero bits; exactly 9 words accepted in total before LOAD.
REQ-037 out_ready held low for 10 cycles in OUT -> out_data and out_valid stable, in_ready low; one cycle of out_ready -> IDLE, in_ready high.
REQ-038 reset driven low after the 6th key word -> outputs zeroed immediately; a fresh 12-word block afterwards produces the correct core_key.
REQ-039 With PICCOLO_KEY_REUSE_EN defined, a second block with in_keep=1 and 4 plaintext words -> same core_key, LOAD follows the 4th word; without the macro, the same stimulus -> those words are taken as key words 0..3.
REQ-040 in_valid toggled every other cycle -> same results as continuous input, with no word dropped or duplicated.
